// File: rtl/cache_write_buffer.sv
// Posted write buffer between a write-through cache and memory.
// FIFO of stores drained over req/ack, with coalescing and read-miss forwarding.
module cache_write_buffer #(
  parameter  int DEPTH  = 4,
  parameter  int ADDR_W = 32,
  parameter  int DATA_W = 32,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] fwd_addr,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  typedef enum logic {
    S_IDLE,
    S_REQ
  } state_t;

  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;
  state_t            r_state;
  state_t            w_state_nx;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;

  logic [PTR_W-1:0]  w_yng;
  logic [PTR_W-1:0]  w_head_nx;
  logic              w_match_yng;
  logic              w_frozen;
  logic              w_coal_ok;
  logic              w_acc;
  logic              w_push;
  logic              w_coal;
  logic              w_pop;
  logic              w_load;
  logic [ADDR_W-1:0] w_ld_addr;
  logic [DATA_W-1:0] w_ld_data;
  logic              w_unused;

  assign w_unused  = ^fwd_addr[1:0];
  assign w_yng     = r_tail - PTR_W'(1);
  assign w_head_nx = r_head + PTR_W'(1);

  assign w_match_yng = (r_count != '0) &&
    (r_addr[w_yng][ADDR_W-1:2] == wr_addr[ADDR_W-1:2]);

  // The youngest entry is frozen if it is in flight or being loaded this cycle
  assign w_frozen = (r_count == CNT_W'(1)) ||
    ((r_state == S_REQ) && mem_ack && (r_count == CNT_W'(2)));

  assign w_coal_ok = w_match_yng & ~w_frozen;
  assign wr_ready  = (r_count < CNT_W'(DEPTH)) | w_coal_ok;
  assign w_acc     = wr_valid & wr_ready;
  assign w_push    = w_acc & ~w_coal_ok;
  assign w_coal    = w_acc & w_coal_ok;
  assign w_pop     = (r_state == S_REQ) & mem_ack;

  always_comb begin
    w_state_nx = r_state;
    w_load     = 1'b0;
    w_ld_addr  = r_addr[r_head];
    w_ld_data  = r_data[r_head];
    case (r_state)
      S_IDLE: begin
        if (r_count != '0) begin
          w_load     = 1'b1;
          w_state_nx = S_REQ;
        end
      end
      S_REQ: begin
        if (mem_ack) begin
          if (r_count > CNT_W'(1)) begin
            w_load    = 1'b1;
            w_ld_addr = r_addr[w_head_nx];
            w_ld_data = r_data[w_head_nx];
          end else if (w_push) begin
            // Sole entry popped while a store arrives: feed it straight through
            w_load    = 1'b1;
            w_ld_addr = wr_addr;
            w_ld_data = wr_data;
          end else begin
            w_state_nx = S_IDLE;
          end
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_state <= w_state_nx;
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      if (w_push) r_tail <= r_tail + PTR_W'(1);
      if (w_pop)  r_head <= w_head_nx;
      if (w_load) begin
        r_mem_addr  <= w_ld_addr;
        r_mem_wdata <= w_ld_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (w_push) begin
        r_addr[r_tail] <= wr_addr;
        r_data[r_tail] <= wr_data;
      end else if (w_coal) begin
        r_data[w_yng] <= wr_data;
      end
    end
  end

  // Walk oldest to youngest so the youngest match wins
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx      = '0;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = r_head + PTR_W'(i);
      if ((CNT_W'(i) < r_count) &&
          (r_addr[idx][ADDR_W-1:2] == fwd_addr[ADDR_W-1:2])) begin
        fwd_hit  = 1'b1;
        fwd_data = r_data[idx];
      end
    end
  end

  assign mem_req   = (r_state == S_REQ);
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign count     = r_count;
  assign empty     = (r_count == '0);

endmodule

// File: tb/tb_cache_write_buffer.sv
// Directed table-driven bench for cache_write_buffer.
// Each row is one cycle: inputs driven at negedge, outputs checked 1ns later.
module tb_cache_write_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [31:0] fwd_addr;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic        empty;
  logic [2:0]  count;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  cache_write_buffer dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .empty(empty), .count(count)
  );

  typedef struct {
    logic        vi;
    logic [31:0] va;
    logic [31:0] vd;
    logic        ack;
    logic [31:0] fa;
    logic        rdy;
    logic        req;
    logic [31:0] ma;
    logic [31:0] md;
    int          cnt;
    logic        hit;
    logic [31:0] fd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic vi, input logic [31:0] va, input logic [31:0] vd,
    input logic ack, input logic [31:0] fa,
    input logic rdy, input logic req,
    input logic [31:0] ma, input logic [31:0] md,
    input int cnt, input logic hit, input logic [31:0] fd);
    vec_t v;
    v.vi = vi; v.va = va; v.vd = vd; v.ack = ack; v.fa = fa;
    v.rdy = rdy; v.req = req; v.ma = ma; v.md = md;
    v.cnt = cnt; v.hit = hit; v.fd = fd;
    return v;
  endfunction

  task automatic chk(input string nm, input int row,
                     input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s row %0d: got %0h want %0h", nm, row, act, exp);
  endtask

  task automatic drive(input logic vi, input logic [31:0] va,
                       input logic [31:0] vd, input logic ack,
                       input logic [31:0] fa);
    wr_valid = vi; wr_addr = va; wr_data = vd;
    mem_ack = ack; fwd_addr = fa;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_count", -1, 32'(count), 0);
    chk("rst_empty", -1, 32'(empty), 1);
    chk("rst_ready", -1, 32'(wr_ready), 1);
    chk("rst_req",   -1, 32'(mem_req), 0);

    // single store, ack three cycles into the request
    tbl.push_back(mk(1,'h40,111,0,'h40, 1,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,'h40, 1,0,0,0,1,1,111));
    tbl.push_back(mk(0,0,0,0,'h40, 1,1,'h40,111,1,1,111));
    tbl.push_back(mk(0,0,0,0,'h40, 1,1,'h40,111,1,1,111));
    tbl.push_back(mk(0,0,0,0,'h40, 1,1,'h40,111,1,1,111));
    tbl.push_back(mk(0,0,0,1,'h40, 1,1,'h40,111,1,1,111));
    tbl.push_back(mk(0,0,0,0,'h40, 1,0,'h40,111,0,0,0));
    // fill to full, fifth store waits for the pop
    tbl.push_back(mk(1,'h40,1,0,0, 1,0,'h40,111,0,0,0));
    tbl.push_back(mk(1,'h440,2,0,0, 1,0,'h40,111,1,0,0));
    tbl.push_back(mk(1,'hC40,3,0,0, 1,1,'h40,1,2,0,0));
    tbl.push_back(mk(1,'h1C40,4,0,0, 1,1,'h40,1,3,0,0));
    tbl.push_back(mk(1,'h840,5,0,0, 0,1,'h40,1,4,0,0));
    tbl.push_back(mk(1,'h840,5,1,0, 0,1,'h40,1,4,0,0));
    tbl.push_back(mk(1,'h840,5,0,0, 1,1,'h440,2,3,0,0));
    tbl.push_back(mk(0,0,0,1,0, 0,1,'h440,2,4,0,0));
    tbl.push_back(mk(0,0,0,1,0, 1,1,'hC40,3,3,0,0));
    tbl.push_back(mk(0,0,0,1,0, 1,1,'h1C40,4,2,0,0));
    tbl.push_back(mk(0,0,0,1,0, 1,1,'h840,5,1,0,0));
    tbl.push_back(mk(0,0,0,0,0, 1,0,'h840,5,0,0,0));
    // coalesce behind a busy head
    tbl.push_back(mk(1,'h40,7,0,0, 1,0,'h840,5,0,0,0));
    tbl.push_back(mk(1,'h840,5000,0,0, 1,0,'h840,5,1,0,0));
    tbl.push_back(mk(1,'h840,6000,0,'h840, 1,1,'h40,7,2,1,5000));
    tbl.push_back(mk(0,0,0,1,'h840, 1,1,'h40,7,2,1,6000));
    tbl.push_back(mk(0,0,0,1,'h840, 1,1,'h840,6000,1,1,6000));
    tbl.push_back(mk(0,0,0,0,'h840, 1,0,'h840,6000,0,0,0));
    // forwarding, youngest match, frozen head
    tbl.push_back(mk(1,'h440,222,0,0, 1,0,'h840,6000,0,0,0));
    tbl.push_back(mk(1,'hC40,333,0,0, 1,0,'h840,6000,1,0,0));
    tbl.push_back(mk(1,'h442,999,0,'h440, 1,1,'h440,222,2,1,222));
    tbl.push_back(mk(0,0,0,0,'h440, 1,1,'h440,222,3,1,999));
    tbl.push_back(mk(0,0,0,0,'h1000, 1,1,'h440,222,3,0,0));
    tbl.push_back(mk(0,0,0,0,'hC42, 1,1,'h440,222,3,1,333));
    tbl.push_back(mk(0,0,0,1,0, 1,1,'h440,222,3,0,0));
    tbl.push_back(mk(0,0,0,1,0, 1,1,'hC40,333,2,0,0));
    tbl.push_back(mk(1,'h440,55,0,'h440, 1,1,'h442,999,1,1,999));
    tbl.push_back(mk(0,0,0,1,'h440, 1,1,'h442,999,2,1,55));
    tbl.push_back(mk(0,0,0,1,0, 1,1,'h440,55,1,0,0));
    tbl.push_back(mk(0,0,0,0,0, 1,0,'h440,55,0,0,0));
    // push and pop with a single entry, ack while idle
    tbl.push_back(mk(1,'h100,10,0,0, 1,0,'h440,55,0,0,0));
    tbl.push_back(mk(0,0,0,0,'h100, 1,0,'h440,55,1,1,10));
    tbl.push_back(mk(1,'h200,20,1,'h200, 1,1,'h100,10,1,0,0));
    tbl.push_back(mk(0,0,0,1,'h200, 1,1,'h200,20,1,1,20));
    tbl.push_back(mk(0,0,0,1,0, 1,0,'h200,20,0,0,0));
    tbl.push_back(mk(1,'h300,30,1,0, 1,0,'h200,20,0,0,0));
    tbl.push_back(mk(0,0,0,1,0, 1,0,'h200,20,1,0,0));
    tbl.push_back(mk(0,0,0,0,0, 1,1,'h300,30,1,0,0));
    tbl.push_back(mk(0,0,0,1,0, 1,1,'h300,30,1,0,0));
    tbl.push_back(mk(0,0,0,0,0, 1,0,'h300,30,0,0,0));
    // no coalescing into the entry loaded on this ack
    tbl.push_back(mk(1,'h600,60,0,0, 1,0,'h300,30,0,0,0));
    tbl.push_back(mk(1,'h700,70,0,0, 1,0,'h300,30,1,0,0));
    tbl.push_back(mk(1,'h700,71,1,'h700, 1,1,'h600,60,2,1,70));
    tbl.push_back(mk(0,0,0,1,'h700, 1,1,'h700,70,2,1,71));
    tbl.push_back(mk(0,0,0,1,'h700, 1,1,'h700,71,1,1,71));
    tbl.push_back(mk(0,0,0,0,'h700, 1,0,'h700,71,0,0,0));

    for (int r = 0; r < tbl.size(); r++) begin
      @(negedge clk);
      drive(tbl[r].vi, tbl[r].va, tbl[r].vd, tbl[r].ack, tbl[r].fa);
      #1;
      chk("wr_ready",  r, 32'(wr_ready),  32'(tbl[r].rdy));
      chk("mem_req",   r, 32'(mem_req),   32'(tbl[r].req));
      chk("mem_addr",  r, mem_addr,       tbl[r].ma);
      chk("mem_wdata", r, mem_wdata,      tbl[r].md);
      chk("count",     r, 32'(count),     32'(tbl[r].cnt));
      chk("empty",     r, 32'(empty),     32'(tbl[r].cnt == 0));
      chk("fwd_hit",   r, 32'(fwd_hit),   32'(tbl[r].hit));
      chk("fwd_data",  r, fwd_data,       tbl[r].fd);
    end

    // reset mid-drain with three entries and ack during reset
    @(negedge clk); drive(1, 'h10, 1, 0, 'h10);
    @(negedge clk); drive(1, 'h20, 2, 0, 'h10);
    @(negedge clk); drive(1, 'h30, 3, 0, 'h10);
    @(negedge clk); drive(0, 0, 0, 0, 'h10);
    #1;
    chk("pre_rst_count", 100, 32'(count), 3);
    chk("pre_rst_req",   100, 32'(mem_req), 1);
    chk("pre_rst_addr",  100, mem_addr, 'h10);
    rst_n = 1'b0;
    mem_ack = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mem_ack = 1'b0;
    #1;
    chk("post_rst_count", 101, 32'(count), 0);
    chk("post_rst_empty", 101, 32'(empty), 1);
    chk("post_rst_req",   101, 32'(mem_req), 0);
    chk("post_rst_addr",  101, mem_addr, 0);
    chk("post_rst_wdata", 101, mem_wdata, 0);
    chk("post_rst_ready", 101, 32'(wr_ready), 1);
    chk("post_rst_hit",   101, 32'(fwd_hit), 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      mem_ack = 1'b1;
      #1;
      chk("late_ack_count", 102 + k, 32'(count), 0);
      chk("late_ack_req",   102 + k, 32'(mem_req), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
